// File: rtl/param_regfile_clr.sv
// Parametrised register file with separate write and read ports, a registered
// read output with a one-cycle valid strobe, and a hardware clear sequencer that
// sweeps every entry to zero over DEPTH cycles.
//
// Optional build macro REGFILE_WRITE_THROUGH_EN: when defined, a same-address
// write and read at one edge returns the new write data (bypass). When undefined,
// the read returns the value stored before the write (read-before-write).
module param_regfile_clr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AD_W   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AD_W-1:0]   WAD,
  input  logic [DATA_W-1:0] Din,
  input  logic              RE,
  input  logic [AD_W-1:0]   RAD,
  output logic [DATA_W-1:0] Dout,
  output logic              RVALID,
  input  logic              CLR,
  output logic              BUSY
);

  localparam int unsigned DEPTH = 2 ** AD_W;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e            state_q;
  logic [AD_W-1:0]   ptr_q;
  logic [DATA_W-1:0] dout_q;
  logic              rvalid_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  // Accesses are honoured only in idle, and a clear request drops them.
  assign accept = (state_q == StIdle) && !CLR;
  assign wr_en  = accept && WE;
  assign rd_en  = accept && RE;

  // Read data selection for the registered output.
  always_comb begin
    rd_data = mem_q[RAD];
`ifdef REGFILE_WRITE_THROUGH_EN
    if (WE && (WAD == RAD)) begin
      rd_data = Din;
    end
`endif
  end

  // Control FSM with registered read port and busy flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CLR) begin
            state_q  <= StClear;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            rvalid_q <= 1'b0;
          end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
              dout_q <= rd_data;
            end
          end
        end
        StClear: begin
          // Dout deliberately holds its last value during the sweep.
          rvalid_q <= 1'b0;
          ptr_q    <= ptr_q + AD_W'(1);
          if (ptr_q == AD_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: cleared by reset or by the sweep, else written in idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[WAD] <= Din;
    end
  end

  assign Dout   = dout_q;
  assign RVALID = rvalid_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_param_regfile_clr.sv
// Self-checking bench for param_regfile_clr: directed scenarios plus a random
// traffic run, all compared against a behavioural model of the register file.
module tb_param_regfile_clr;

  localparam int DATA_W = 8;
  localparam int AD_W   = 3;
  localparam int DEPTH  = 8;

`ifdef REGFILE_WRITE_THROUGH_EN
  localparam bit WriteThrough = 1'b1;
`else
  localparam bit WriteThrough = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              WE;
  logic [AD_W-1:0]   WAD;
  logic [DATA_W-1:0] Din;
  logic              RE;
  logic [AD_W-1:0]   RAD;
  logic [DATA_W-1:0] Dout;
  logic              RVALID;
  logic              CLR;
  logic              BUSY;

  param_regfile_clr #(
    .DATA_W(DATA_W),
    .AD_W  (AD_W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .WAD   (WAD),
    .Din   (Din),
    .RE    (RE),
    .RAD   (RAD),
    .Dout  (Dout),
    .RVALID(RVALID),
    .CLR   (CLR),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: an array, the last read value, and a count of clear
  // cycles still to run.
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] dout_m;
  logic              rvalid_m;
  logic              busy_m;
  int                clear_left;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    dout_m     = '0;
    rvalid_m   = 1'b0;
    busy_m     = 1'b0;
    clear_left = 0;
  endtask

  task automatic idle_inputs();
    WE  = 1'b0;
    RE  = 1'b0;
    CLR = 1'b0;
    WAD = '0;
    RAD = '0;
    Din = '0;
  endtask

  // Advance one clock: inputs were set at the previous falling edge, the model
  // applies them at the rising edge, and outputs are looked at on the next
  // falling edge.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      if (clear_left > 0) begin
        // The k-th sweep edge zeroes entry k (0-based).
        mem_m[DEPTH - clear_left] = '0;
        clear_left--;
        rvalid_m = 1'b0;
        busy_m   = (clear_left > 0);
      end else if (CLR) begin
        clear_left = DEPTH;
        busy_m     = 1'b1;
        rvalid_m   = 1'b0;
      end else begin
        rvalid_m = RE;
        if (RE) begin
          if (WE && WAD == RAD && WriteThrough) dout_m = Din;
          else dout_m = mem_m[RAD];
        end
        if (WE) mem_m[WAD] = Din;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_write(input logic [AD_W-1:0] a, input logic [DATA_W-1:0] d);
    WE = 1'b1; WAD = a; Din = d;
    step();
    WE = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    model_reset();
    step();
    step();
    checks++;
    if (Dout !== 8'h00 || RVALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Dout=%h RVALID=%b BUSY=%b, need 00/0/0", Dout, RVALID, BUSY);
    end
    RST = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      RE = 1'b1; RAD = AD_W'(a);
      step();
      checks++;
      if (Dout !== 8'h00 || RVALID !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_readback[%0d]: Dout=%h RVALID=%b BUSY=%b, need 00/1/0",
                 a, Dout, RVALID, BUSY);
      end
    end
    RE = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_write(3'd3, 8'hA5);
    do_write(3'd7, 8'h3C);
    RE = 1'b1; RAD = 3'd3;
    step();
    checks++;
    if (Dout !== 8'hA5 || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL basic_rd3: Dout=%h RVALID=%b, need a5/1", Dout, RVALID);
    end
    RAD = 3'd7;
    step();
    checks++;
    if (Dout !== 8'h3C || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL basic_rd7: Dout=%h RVALID=%b, need 3c/1", Dout, RVALID);
    end
    RE = 1'b0;
    step();
    checks++;
    if (Dout !== 8'h3C || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: Dout=%h RVALID=%b, need 3c/0", Dout, RVALID);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] exp_first;
    exp_first = WriteThrough ? 8'h22 : 8'h11;
    do_write(3'd2, 8'h11);
    WE = 1'b1; WAD = 3'd2; Din = 8'h22; RE = 1'b1; RAD = 3'd2;
    step();
    WE = 1'b0;
    checks++;
    if (Dout !== exp_first || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL collision_rd: Dout=%h RVALID=%b, need %h/1", Dout, RVALID, exp_first);
    end
    step();
    checks++;
    if (Dout !== 8'h22 || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL collision_after: Dout=%h RVALID=%b, need 22/1", Dout, RVALID);
    end
    RE = 1'b0;
    step();
  endtask

  // Runs a full clear; in busy cycle poke_cycle (1-based, 0 = none) it tries a
  // write of 8'h77 to address 5 together with a read.
  task automatic run_clear(input int poke_cycle, input string tag);
    logic [DATA_W-1:0] held;
    held = Dout;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (BUSY !== 1'b1 || RVALID !== 1'b0 || Dout !== held) begin
        errors++;
        $display("FAIL %s_busy[%0d]: BUSY=%b RVALID=%b Dout=%h, need 1/0/%h",
                 tag, i, BUSY, RVALID, Dout, held);
      end
      if (i == poke_cycle) begin
        WE = 1'b1; WAD = 3'd5; Din = 8'h77; RE = 1'b1; RAD = 3'd5;
      end
      step();
      WE = 1'b0; RE = 1'b0;
    end
    checks++;
    if (BUSY !== 1'b0 || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: BUSY=%b RVALID=%b, need 0/0", tag, BUSY, RVALID);
    end
    for (int a = 0; a < DEPTH; a++) begin
      RE = 1'b1; RAD = AD_W'(a);
      step();
      checks++;
      if (Dout !== 8'h00 || RVALID !== 1'b1) begin
        errors++;
        $display("FAIL %s_rd[%0d]: Dout=%h RVALID=%b, need 00/1", tag, a, Dout, RVALID);
      end
    end
    RE = 1'b0;
    step();
  endtask

  task automatic test_clear();
    for (int a = 0; a < DEPTH; a++) do_write(AD_W'(a), 8'hFF);
    run_clear(0, "clear");
  endtask

  task automatic test_busy_access();
    for (int a = 0; a < DEPTH; a++) do_write(AD_W'(a), 8'h5A ^ 8'(a));
    run_clear(3, "busyacc");
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < DEPTH; a++) do_write(AD_W'(a), 8'hC0 | 8'(a));
    RE = 1'b1; RAD = 3'd6;
    step();
    RE = 1'b0;
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    for (int i = 1; i < 4; i++) step();
    // Now in the 4th busy cycle; reset lands between edges.
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || Dout !== 8'h00 || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL midclr_async: BUSY=%b Dout=%h RVALID=%b, need 0/00/0", BUSY, Dout, RVALID);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      RE = 1'b1; RAD = AD_W'(a);
      step();
      checks++;
      if (Dout !== 8'h00 || RVALID !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL midclr_rd[%0d]: Dout=%h RVALID=%b BUSY=%b, need 00/1/0",
                 a, Dout, RVALID, BUSY);
      end
    end
    RE = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      WE  = 1'($urandom_range(0, 1));
      RE  = 1'($urandom_range(0, 1));
      CLR = ($urandom_range(0, 39) == 0);
      WAD = AD_W'($urandom);
      RAD = AD_W'($urandom);
      Din = DATA_W'($urandom);
      step();
      checks++;
      if (Dout !== dout_m || RVALID !== rvalid_m || BUSY !== busy_m) begin
        errors++;
        $display("FAIL random[%0d]: Dout=%h RVALID=%b BUSY=%b, need %h/%b/%b",
                 n, Dout, RVALID, BUSY, dout_m, rvalid_m, busy_m);
      end
    end
    idle_inputs();
    while (clear_left > 0) step();
    for (int a = 0; a < DEPTH; a++) begin
      RE = 1'b1; RAD = AD_W'(a);
      step();
      checks++;
      if (Dout !== dout_m || RVALID !== 1'b1) begin
        errors++;
        $display("FAIL random_dump[%0d]: Dout=%h RVALID=%b, need %h/1", a, Dout, RVALID, dout_m);
      end
    end
    RE = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_basic();
    test_collision();
    test_clear();
    test_busy_access();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_regfile_clr.md
Name: param_regfile_clr

Overview:
- Parametrised synchronous register-file memory with separate write and read ports, a registered read output with a valid strobe, and a hardware clear sequencer.
- Generalises the fixed 4x4 single-port RW memory block in width and depth.
- Sits between lab datapath logic and any block needing small scratch storage with a known-zero restart.

Parameters:
DATA_W, 8, data word width in bits
AD_W, 3, address width; DEPTH = 2**AD_W entries (default 8)

Ports:
CLK  input  1  single system clock, rising-edge
RST  input  1  reset, asynchronous, active-low
WE  input  1  write enable
WAD  input  AD_W  write address
Din  input  DATA_W  write data
RE  input  1  read enable
RAD  input  AD_W  read address
Dout  output  DATA_W  registered read data
RVALID  output  1  one-cycle strobe, Dout updated this cycle
CLR  input  1  clear request (level sampled per edge)
BUSY  output  1  clear sequence in progress; accesses ignored

Behaviour:
- Reset:
  - RST=0 asynchronously forces all DEPTH entries to 0, Dout=0, RVALID=0, BUSY=0, clear pointer=0, FSM=IDLE.
  - Reset release takes effect at the next rising CLK edge.
- FSM states:
  - IDLE: normal access.
  - CLEAR: sweeping the array.
- IDLE, CLR=1 at an edge:
  - Go to CLEAR; clear pointer=0; BUSY=1 from the following cycle.
  - CLR has priority: a WE or RE sampled at the same edge is dropped. No write; RVALID stays 0.
- CLEAR, each edge:
  - mem[pointer] <= 0; pointer increments.
  - After writing entry DEPTH-1, return to IDLE.
  - BUSY is high for exactly DEPTH cycles, and pointer wraps to 0.
- CLEAR, other inputs:
  - WE, RE and CLR are ignored; RVALID=0.
  - Dout holds its last value; it is not zeroed.
- Write: in IDLE with WE=1 and CLR=0 at an edge, mem[WAD] <= Din.
- Read:
  - In IDLE with RE=1 and CLR=0 at an edge, Dout <= mem[RAD] at that edge; RVALID=1 for exactly that following cycle.
  - Latency is 1 cycle from the RE sample to valid data.
  - With RE=0, RVALID=0 and Dout holds.
- Back-to-back reads: every cycle allowed; RVALID stays high continuously.
- Write and read at the same edge, different addresses: both take effect independently.
- Write and read at the same edge, same address: result is governed by the Optional Feature.
- Addresses are full-range (0..DEPTH-1); no out-of-range case exists.
- Reset mid-CLEAR: aborts immediately; FSM=IDLE, BUSY=0, array all zeros.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_WRITE_THROUGH_EN
- Defined: same-address simultaneous WE/RE returns the new Din on Dout (write-through bypass mux).
- Undefined: same-address simultaneous WE/RE returns the old stored value (read-before-write).
- The stored value after the edge is Din in both cases.

Test Plan:
- Reset and read-back:
  - Stimulus: hold RST=0 for 2 cycles, release, then RE for addresses 0..7.
  - Required: Dout=8'h00 each time, RVALID high 8 consecutive cycles, BUSY=0.
- Write/read basic:
  - Stimulus: write 8'hA5 to address 3 and 8'h3C to address 7, then RE with RAD=3 and then RAD=7.
  - Required: Dout=8'hA5 then 8'h3C, each one cycle after its RE, with RVALID pulses aligned.
- Same-address collision:
  - Stimulus: address 2 holds 8'h11; at one edge WE=1, WAD=2, Din=8'h22, RE=1, RAD=2.
  - Required: Dout=8'h11 without the macro, 8'h22 with it; a following read returns 8'h22 in both builds.
- Clear sequence:
  - Stimulus: fill all 8 entries with 8'hFF, then pulse CLR for 1 cycle.
  - Required: BUSY=1 for exactly 8 cycles; reads after that return 8'h00 for all addresses.
- Access during BUSY:
  - Stimulus: assert WE (address 5, 8'h77) and RE in the 3rd BUSY cycle.
  - Required: RVALID stays 0; after the clear, address 5 reads 8'h00.
- Reset mid-clear:
  - Stimulus: drive RST=0 asynchronously (between edges) during the 4th BUSY cycle.
  - Required: BUSY drops to 0 immediately without waiting for an edge; Dout=0, RVALID=0; after release, CLR-free reads of all entries return 8'h00.
